// File: rtl/reg_pipe_elastic.sv
// Elastic multi-stage register: DEPTH stages of WIDTH-bit data with per-stage
// valid bits, valid/ready on both ends, bubble collapsing, flush and occupancy.
module reg_pipe_elastic #(
  parameter int unsigned      width = 1,
  parameter int unsigned      depth = 2,
  parameter logic [width-1:0] init  = '0,
  localparam int unsigned     cntw  = $clog2(depth + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ_VALID,
  output logic             ENQ_READY,
  input  logic [width-1:0] ENQ_DATA,
  output logic             DEQ_VALID,
  input  logic             DEQ_READY,
  output logic [width-1:0] DEQ_DATA,
  input  logic             FLUSH,
  output logic [cntw-1:0]  COUNT
);

  logic [depth-1:0] v_q;
  logic [depth-1:0] v_d;
  logic [depth-1:0] mv;
  logic [width-1:0] d_q [depth];
  logic [width-1:0] d_d [depth];
  logic             live;
  logic             enq_fire;

  // Handshakes are suppressed while reset or flush is asserted.
  assign live      = RST & ~FLUSH;
  assign ENQ_READY = live & (~v_q[0] | mv[0]);
  assign DEQ_VALID = live & v_q[depth-1];
  assign DEQ_DATA  = d_q[depth-1];
  assign enq_fire  = ENQ_VALID & ENQ_READY;

  // Move chain evaluated from the output stage backwards; a stage advances
  // when the next stage is empty or is itself advancing.
  always_comb begin : move_chain
    logic m_up;
    mv          = '0;
    m_up        = v_q[depth-1] & DEQ_READY;
    mv[depth-1] = m_up;
    for (int unsigned k = 1; k < depth; k++) begin
      m_up            = v_q[depth-1-k] & (~v_q[depth-k] | m_up);
      mv[depth-1-k]   = m_up;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (enq_fire) begin
      v_d[0] = 1'b1;
      d_d[0] = ENQ_DATA;
    end else if (mv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int unsigned k = 1; k < depth; k++) begin
      if (mv[k-1]) begin
        v_d[k] = 1'b1;
        d_d[k] = d_q[k-1];
      end else if (mv[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    COUNT = '0;
    for (int unsigned k = 0; k < depth; k++) begin
      COUNT = COUNT + cntw'(v_q[k]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      v_q <= '0;
      for (int unsigned k = 0; k < depth; k++) begin
        d_q[k] <= init;
      end
    end else if (FLUSH) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Scoreboard bench for reg_pipe_elastic (width=8, depth=3, init=8'h5A): directed
// scenarios followed by a random valid/ready/flush/reset soak.
module tb_reg_pipe_elastic;

  localparam int DEPTH = 3;
  localparam logic [7:0] INIT = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enq_valid = 1'b0;
  logic       enq_ready;
  logic [7:0] enq_data = '0;
  logic       deq_valid;
  logic       deq_ready = 1'b0;
  logic [7:0] deq_data;
  logic       flush = 1'b0;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         t;
  } item_t;

  item_t sbq[$];
  int    last_dep = -1000;

  reg_pipe_elastic #(
    .width(8),
    .depth(DEPTH),
    .init (INIT)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .ENQ_VALID(enq_valid),
    .ENQ_READY(enq_ready),
    .ENQ_DATA (enq_data),
    .DEQ_VALID(deq_valid),
    .DEQ_READY(deq_ready),
    .DEQ_DATA (deq_data),
    .FLUSH    (flush),
    .COUNT    (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: an ordered queue of accepted items. An item can reach the
  // output no earlier than DEPTH cycles after acceptance and no earlier than
  // the cycle after its predecessor left. Acceptance is possible whenever the
  // pipe is not full, or when it is full and the consumer is taking an item.
  always @(negedge clk) begin
    int    exp_cnt;
    int    avail;
    bit    exp_rdy;
    bit    exp_vld;
    item_t it;
    exp_cnt = sbq.size();
    exp_rdy = rst && !flush && (exp_cnt < DEPTH || deq_ready);
    exp_vld = 1'b0;
    if (rst && !flush && exp_cnt > 0) begin
      avail = sbq[0].t + DEPTH;
      if (last_dep + 1 > avail) avail = last_dep + 1;
      exp_vld = (cyc >= avail);
    end
    check("enq_ready", int'(enq_ready), int'(exp_rdy));
    check("deq_valid", int'(deq_valid), int'(exp_vld));
    if (rst) check("count", int'(count), exp_cnt);
    if (exp_vld && deq_ready) begin
      it = sbq.pop_front();
      check("deq_data", int'(deq_data), int'(it.data));
      last_dep = cyc;
    end
    if (enq_valid && exp_rdy) sbq.push_back('{enq_data, cyc});
    if (!rst || flush) sbq.delete();
  end

  task automatic set_in(input logic ev, input logic [7:0] ed, input logic dr,
                        input logic fl, input logic rs);
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    rst       = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    // 1: reset
    set_in(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    step(); step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_deq_valid", int'(deq_valid), 0);
    check("rst_deq_data", int'(deq_data), int'(INIT));
    check("rst_count", int'(count), 0);
    check("rst_enq_ready", int'(enq_ready), 1);
    step();

    // 2: streaming 01..08 with the consumer always ready
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("stream_enq_ready", int'(enq_ready), 1);
      step();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (5) step();

    // 3: back-pressure
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      step();
    end
    set_in(1'b1, 8'h13, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_count", int'(count), 3);
    check("bp_enq_ready", int'(enq_ready), 0);
    step();
    @(negedge clk);
    check("bp_hold_enq_ready", int'(enq_ready), 0);
    step();
    set_in(1'b1, 8'h13, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (5) step();

    // 4: bubble collapse
    set_in(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(); step();
    set_in(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    check("bub_count", int'(count), 2);
    check("bub_deq_data", int'(deq_data), 8'hA0);
    check("bub_enq_ready", int'(enq_ready), 1);
    step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (5) step();

    // 5: flush
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b1);
      step();
    end
    set_in(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("fl_enq_ready", int'(enq_ready), 0);
    check("fl_deq_valid", int'(deq_valid), 0);
    step();
    set_in(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("fl_after_count", int'(count), 0);
    check("fl_after_deq_valid", int'(deq_valid), 0);
    check("fl_after_enq_ready", int'(enq_ready), 1);
    step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step();
    @(negedge clk);
    check("lat_early_valid", int'(deq_valid), 0);
    step();
    @(negedge clk);
    check("lat_valid", int'(deq_valid), 1);
    check("lat_data", int'(deq_data), 8'h77);
    step();
    repeat (3) step();

    // 6: reset mid-stream
    set_in(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("mrst_count", int'(count), 0);
    check("mrst_deq_data", int'(deq_data), int'(INIT));
    check("mrst_deq_valid", int'(deq_valid), 0);
    repeat (5) step();

    // random soak with occasional flush and reset
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 31) == 0, $urandom_range(0, 127) != 0);
      step();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (8) step();
    @(negedge clk);
    check("drain_count", int'(count), 0);
    check("drain_deq_valid", int'(deq_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
